mealy_step_scheduler: RTL and testbench
=======================================

Name: mealy_step_scheduler

Overview:
Round-robin scheduler that shares one 4-state step-counting Mealy FSM (S0->S1->S2->S3, S3->S1 on each step; holds when idle) between two requesters.
- Each requester hands over a burst length through a valid/ready handshake.
- The scheduler drives the FSM's step input with single-cycle pulses separated by a programmable gap.
- It mirrors the FSM state in a shadow register and issues the FSM's synchronous reset once after power-up.
- It sits between the request logic and the FSM instance.

Parameters:
- LEN_W, 4, width of burst length fields.
- GAP_W, 3, width of inter-step gap field (idle cycles between step pulses).

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- req0_valid  input  1  requester 0 burst request
- req0_len  input  LEN_W  requester 0 step count
- req0_ready  output  1  requester 0 accept
- req1_valid  input  1  requester 1 burst request
- req1_len  input  LEN_W  requester 1 step count
- req1_ready  output  1  requester 1 accept
- gap  input  GAP_W  idle cycles between pulses; sampled at accept
- step_out  output  1  step pulse to the FSM's in input
- fsm_rst  output  1  synchronous reset to the FSM
- busy  output  1  burst in progress
- grant_id  output  1  owner of current or last burst
- done  output  1  one-cycle burst-complete pulse
- shadow_state  output  2  mirrored FSM state

Interface: one clock; reset is asynchronous and active-low. rst=0 asynchronously clears all registers; all outputs are registered except the readys.

Behaviour:
- Reset values: step_out=0, busy=0, done=0, grant_id=0, shadow_state=0, state=INIT, fsm_rst=1.
- INIT: fsm_rst=1 for exactly one cycle after rst deasserts, then go to IDLE with fsm_rst=0. fsm_rst is never asserted again.
- IDLE:
  - Arbitration is combinational. If only one valid is high, that requester wins.
  - If both are high, the requester that is not grant_id wins (round-robin). After reset, requester 1 wins a first tie.
  - Only the winner's ready is high; both readys are 0 outside IDLE.
  - Accept when valid&&ready. On accept, latch len into remaining and gap into gap_cfg, set grant_id and busy=1.
  - If len==0, go to DONE; otherwise go to STEP.
- STEP (one cycle):
  - step_out=1; remaining decrements.
  - shadow_state advances S0->S1->S2->S3->S1 at the end of the cycle.
  - If remaining was 1, go to DONE.
  - Otherwise, if gap_cfg==0 go to STEP; else go to GAP with gap_cnt=gap_cfg.
- GAP: step_out=0; gap_cnt decrements each cycle; when it reaches 1, go to STEP. Produces exactly gap_cfg idle cycles.
- DONE (one cycle): done=1, busy=0 at exit, then IDLE. No accept occurs in the DONE cycle.
- Latency: accept at cycle t gives the first step at t+1 and done at t+1+len+(len-1)*gap_cfg. With len=0, done is at t+1.
- len and gap inputs are ignored after accept; changing them mid-burst has no effect.
- A valid dropping without ready is legal; no request is queued.
- rst asserted mid-burst: immediate abort to INIT with reset values, and fsm_rst is reissued after release.
- shadow_state is unaffected by bursts of length 0 and by gaps.

Optional Feature:
Macro: MEALY_STEP_SCHED_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in STEP or GAP suppresses any further pulses: the next state is DONE, and a step already in the current STEP cycle still completes.
  - Adds output aborted (1 bit), high with done when the burst was cut short, else 0; reset value 0.
  - abort in IDLE, INIT or DONE is ignored.
- Undefined: neither port exists, and bursts always run to completion.

Test Plan:
- Reset release, no requests -> fsm_rst=1 for one cycle, then 0; shadow_state=0; both readys 1 only while the corresponding valid is high.
- req0 len=3, gap=0 accepted at cycle t -> step_out=1 at t+1..t+3, done at t+4, shadow_state 0->1->2->3, grant_id=0.
- req1 len=2, gap=2 starting from shadow=3 -> steps at t+1 and t+4, done at t+5, shadow_state 3->1->2.
- Both valid continuously with len=1 -> grants alternate 1,0,1,0; each done is followed by an accept on the next IDLE cycle.
- len=0 request -> done at t+1, step_out never asserted, shadow_state unchanged; rst pulled low mid-burst of len=5 -> outputs at reset values immediately, fsm_rst pulse after release.
- With MEALY_STEP_SCHED_ABORT_EN: len=6, gap=1, abort at the 2nd GAP cycle -> exactly 2 steps, done=1 with aborted=1 on the next cycle.

Source files
------------

// File: rtl/mealy_step_scheduler.sv
// Round-robin scheduler feeding a shared 4-state step-counting FSM with gapped step pulses.
// Optional abort input/aborted output are built when MEALY_STEP_SCHED_ABORT_EN is defined.
module mealy_step_scheduler #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_ready,
  input  logic [GAP_W-1:0] gap,
  output logic             step_out,
  output logic             fsm_rst,
  output logic             busy,
  output logic             grant_id,
  output logic             done,
  output logic [1:0]       shadow_state
`ifdef MEALY_STEP_SCHED_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  typedef enum logic [2:0] {StInit, StIdle, StStep, StGap, StDone} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] remaining_q;
  logic [GAP_W-1:0] gap_cfg_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             win1;
  logic             accept;
  logic [LEN_W-1:0] acc_len;
  logic             abort_hit;

`ifdef MEALY_STEP_SCHED_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // On a tie the requester that did not own the last burst wins.
  always_comb begin
    win1       = req1_valid & (~req0_valid | ~grant_id);
    req1_ready = (state_q == StIdle) & win1;
    req0_ready = (state_q == StIdle) & req0_valid & ~win1;
    accept     = req0_ready | req1_ready;
    acc_len    = win1 ? req1_len : req0_len;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StInit;
      remaining_q  <= '0;
      gap_cfg_q    <= '0;
      gap_cnt_q    <= '0;
      step_out     <= 1'b0;
      fsm_rst      <= 1'b1;
      busy         <= 1'b0;
      grant_id     <= 1'b0;
      done         <= 1'b0;
      shadow_state <= 2'd0;
    end else begin
      step_out <= 1'b0;
      done     <= 1'b0;
      unique case (state_q)
        StInit: begin
          fsm_rst <= 1'b0;
          state_q <= StIdle;
        end
        StIdle: begin
          if (accept) begin
            grant_id    <= win1;
            busy        <= 1'b1;
            remaining_q <= acc_len;
            gap_cfg_q   <= gap;
            if (acc_len == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q  <= StStep;
              step_out <= 1'b1;
            end
          end
        end
        StStep: begin
          remaining_q  <= remaining_q - LEN_W'(1);
          // Mirrors the FSM: S0->S1->S2->S3, then S3 wraps to S1.
          shadow_state <= (shadow_state == 2'd3) ? 2'd1 : shadow_state + 2'd1;
          if (remaining_q == LEN_W'(1) || abort_hit) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else if (gap_cfg_q == '0) begin
            state_q  <= StStep;
            step_out <= 1'b1;
          end else begin
            state_q   <= StGap;
            gap_cnt_q <= gap_cfg_q;
          end
        end
        StGap: begin
          if (abort_hit) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else if (gap_cnt_q == GAP_W'(1)) begin
            state_q  <= StStep;
            step_out <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StInit;
      endcase
    end
  end

`ifdef MEALY_STEP_SCHED_ABORT_EN
  // A burst counts as cut short only if steps were still pending when abort hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aborted <= 1'b0;
    end else if (state_q == StDone) begin
      aborted <= 1'b0;
    end else if (abort && ((state_q == StStep && remaining_q != LEN_W'(1)) ||
                           state_q == StGap)) begin
      aborted <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mealy_step_scheduler.sv
// Bench for mealy_step_scheduler: directed steps then random traffic against a timeline model.
module tb_mealy_step_scheduler;
  localparam int LEN_W = 4;
  localparam int GAP_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [LEN_W-1:0] req0_len = '0, req1_len = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             req0_ready, req1_ready, step_out, fsm_rst, busy, grant_id, done;
  logic [1:0]       shadow_state;
  logic             abort = 1'b0;
`ifdef MEALY_STEP_SCHED_ABORT_EN
  logic             aborted;
`endif

  mealy_step_scheduler #(.LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_len(req1_len), .req1_ready(req1_ready),
    .gap(gap), .step_out(step_out), .fsm_rst(fsm_rst), .busy(busy),
    .grant_id(grant_id), .done(done), .shadow_state(shadow_state)
`ifdef MEALY_STEP_SCHED_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // Model: the current burst is described by its accept cycle, length, gap and done cycle.
  int cyc, init_c, acc_c, d_c, len_m, gap_m, n_steps;
  bit grant_m, exp_ab;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit step_at(int c);
    return c > acc_c && c < d_c && ((c - acc_c - 1) % (gap_m + 1)) == 0;
  endfunction

  function automatic int shadow_exp();
    return (n_steps == 0) ? 0 : ((n_steps - 1) % 3) + 1;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_step_out", step_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_shadow", shadow_state, 0);
    chk("rst_fsm_rst", fsm_rst, 1);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
`ifdef MEALY_STEP_SCHED_ABORT_EN
    chk("rst_aborted", aborted, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0; init_c = 0; acc_c = -100; d_c = -100; gap_m = 0; len_m = 0;
    n_steps = 0; grant_m = 1'b0; exp_ab = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("init_fsm_rst", fsm_rst, 1);
    chk("init_ready0", req0_ready, 0);
    chk("init_ready1", req1_ready, 0);
  endtask

  task automatic cycle(input bit v0, input bit v1, input int l0, input int l1, input int g,
                       input bit ab);
    bit idle, w0, w1;
    @(negedge clk);
    cyc++;
    chk("fsm_rst", fsm_rst, 32'(cyc == init_c));
    chk("step_out", step_out, 32'(step_at(cyc)));
    chk("done", done, 32'(cyc == d_c));
    chk("busy", busy, 32'(cyc > acc_c && cyc <= d_c));
    chk("grant_id", grant_id, 32'(grant_m));
    chk("shadow", shadow_state, shadow_exp());
`ifdef MEALY_STEP_SCHED_ABORT_EN
    chk("aborted", aborted, 32'(cyc == d_c && exp_ab));
`endif
    if (step_at(cyc)) n_steps++;
    req0_valid = v0; req1_valid = v1;
    req0_len = LEN_W'(l0); req1_len = LEN_W'(l1); gap = GAP_W'(g); abort = ab;
    #1;
    idle = cyc > init_c && cyc > d_c;
    w1 = idle && v1 && (!v0 || !grant_m);
    w0 = idle && v0 && !w1;
    chk("ready0", req0_ready, 32'(w0));
    chk("ready1", req1_ready, 32'(w1));
`ifdef MEALY_STEP_SCHED_ABORT_EN
    if (ab && cyc > acc_c && cyc < d_c) begin
      exp_ab = (cyc + 1 < d_c);
      d_c = cyc + 1;
    end
`endif
    if (w0 || w1) begin
      acc_c = cyc; grant_m = w1; len_m = w1 ? l1 : l0; gap_m = g; exp_ab = 1'b0;
      d_c = cyc + 1 + len_m + ((len_m > 0) ? (len_m - 1) * gap_m : 0);
    end
  endtask

  initial begin
    #2;
    do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // req0 len=3 gap=0, inputs scrambled mid-burst
    cycle(1, 0, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 15, 15, 7, 0);
    // req1 len=2 gap=2 starting from shadow=3
    cycle(0, 1, 0, 2, 2, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 9, 9, 5, 0);
    // both valid, len=1: grants alternate
    for (int i = 0; i < 12; i++) cycle(1, 1, 1, 1, 0, 0);
    // zero-length burst
    cycle(1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    // abort-by-reset mid-burst of len=5
    cycle(0, 1, 0, 5, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
`ifdef MEALY_STEP_SCHED_ABORT_EN
    // len=6 gap=1, abort on second GAP cycle
    cycle(1, 0, 6, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
`endif
    for (int i = 0; i < 600; i++) begin
      bit ab;
      ab = 1'b0;
`ifdef MEALY_STEP_SCHED_ABORT_EN
      ab = ($urandom_range(0, 15) == 0);
`endif
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
            ($urandom_range(0, 4) == 0) ? 7 : int'($urandom_range(0, 3)), ab);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
